// File: rtl/morse_tx.sv
// Morse-code transmitter for a packed BCD word, most significant digit first.
// Digits are 5-symbol codes; marks and spaces are timed in units of UNIT_CYCLES clocks.
module morse_tx #(
   parameter int DIGITS      = 4,
   parameter int UNIT_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ready,
   input  logic [4*DIGITS-1:0]   number,
   output logic                  tone,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CW = $clog2(3*UNIT_CYCLES + 1);
   localparam logic [CW-1:0] DOT_M1  = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] DASH_M1 = CW'(3*UNIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, MARK, SPACE, GAP, DONE} state_t;

   state_t              state, state_n;
   logic [4*DIGITS-1:0] word, word_n;
   logic [2:0]          sym, sym_n;
   logic [3:0]          dig, dig_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic                bad_bcd;
   logic [3:0]          top;

   assign top = word[4*DIGITS-1 -: 4];

   // Digits 0..5 are dots then dashes; 6..9 are dashes then dots.
   function automatic logic is_dash(input logic [3:0] d, input logic [2:0] s);
      if (d <= 4'd5) return ({1'b0, s} >= d);
      else           return ({1'b0, s} < (d - 4'd5));
   endfunction

   always_comb begin
      bad_bcd = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (number[4*i +: 4] > 4'd9) bad_bcd = 1'b1;
   end

   // The unit counter counts down; a phase ends when it reaches zero.
   always_comb begin
      state_n = state;
      word_n  = word;
      sym_n   = sym;
      dig_n   = dig;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (ready && !bad_bcd) begin
               state_n = MARK;
               word_n  = number;
               sym_n   = 3'd0;
               dig_n   = 4'(DIGITS - 1);
               cnt_n   = is_dash(number[4*DIGITS-1 -: 4], 3'd0) ? DASH_M1 : DOT_M1;
            end
         end
         MARK: begin
            if (cnt != '0) begin
               cnt_n = cnt - CW'(1);
            end else if (sym != 3'd4) begin
               state_n = SPACE;
               cnt_n   = DOT_M1;
            end else if (dig != 4'd0) begin
               state_n = GAP;
               cnt_n   = DASH_M1;
               word_n  = word << 4;
               dig_n   = dig - 4'd1;
               sym_n   = 3'd0;
            end else begin
               state_n = DONE;
            end
         end
         SPACE: begin
            if (cnt != '0) begin
               cnt_n = cnt - CW'(1);
            end else begin
               state_n = MARK;
               sym_n   = sym + 3'd1;
               cnt_n   = is_dash(top, sym + 3'd1) ? DASH_M1 : DOT_M1;
            end
         end
         GAP: begin
            if (cnt != '0) begin
               cnt_n = cnt - CW'(1);
            end else begin
               state_n = MARK;
               cnt_n   = is_dash(top, 3'd0) ? DASH_M1 : DOT_M1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         word  <= '0;
         sym   <= '0;
         dig   <= '0;
         cnt   <= '0;
         tone  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         word  <= word_n;
         sym   <= sym_n;
         dig   <= dig_n;
         cnt   <= cnt_n;
         tone  <= (state_n == MARK);
         busy  <= (state_n != IDLE);
         done  <= (state_n == DONE);
         if (state == IDLE && ready) err <= bad_bcd;
      end
   end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits per word, legal range 1..8.
REQ-002 SHALL have parameter UNIT_CYCLES, default 4: clock cycles per Morse time unit, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ready, input, 1 bit: start strobe; the word is accepted when ready=1 is sampled while idle.
REQ-006 SHALL have port number, input, 4*DIGITS bits: packed BCD word; the most significant nibble is transmitted first.
REQ-007 SHALL have port tone, output, 1 bit: Morse key; 1 = mark (key down), 0 = space.
REQ-008 SHALL have port busy, output, 1 bit: transmission in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at end of word.
REQ-010 SHALL have port err, output, 1 bit: the last request contained a non-BCD nibble.

Function
REQ-011 SHALL encode digits as exactly 5 symbols each: 0 -----, 1 .----, 2 ..---, 3 ...--, 4 ....-, 5 ....., 6 -...., 7 --..., 8 ---.., 9 ----. (symbols sent left to right).
REQ-012 SHALL time symbols and gaps as follows:
- dot: 1 unit mark
- dash: 3 units mark
- between symbols of a digit: 1 unit space
- between digits: 3 units space
- no trailing space after the last symbol
- 1 unit = UNIT_CYCLES cycles
REQ-013 SHALL implement states IDLE, MARK, SPACE, GAP, DONE.
REQ-014 IDLE, ready=1, all nibbles <=9: SHALL capture number into an internal shift register, clear err, and enter MARK for digit DIGITS-1, symbol 0; tone=1 starting the next cycle.
REQ-015 IDLE, ready=1, any nibble >9: SHALL set err=1 from the next cycle, transmit nothing, and remain IDLE with busy=0.
REQ-016 MARK end, symbol index <4: SHALL enter SPACE; SPACE end enters MARK for the next symbol.
REQ-017 MARK end, symbol 4, digits remaining: SHALL enter GAP; GAP end enters MARK for symbol 0 of the next lower digit.
REQ-018 MARK end, symbol 4, last digit: SHALL enter DONE for exactly 1 cycle with done=1 and tone=0, then return to IDLE.
REQ-019 busy SHALL be 1 in MARK, SPACE, GAP and DONE, and 0 in IDLE.
REQ-020 tone SHALL be 1 only in MARK and SHALL be registered (glitch-free).
REQ-021 ready SHALL be ignored while busy=1; the captured word SHALL NOT change when number changes mid-transmission.
REQ-022 ready=1 in the same cycle DONE returns to IDLE SHALL NOT be accepted; acceptance requires ready sampled in IDLE.
REQ-023 err SHALL hold its value until the next accepted valid request or reset.
REQ-024 unit counter SHALL be wide enough for 3*UNIT_CYCLES-1 without overflow.
REQ-025 total busy cycles before DONE SHALL equal UNIT_CYCLES*(sum of mark units + 4*DIGITS inter-symbol units + 3*(DIGITS-1) gap units).

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, tone=0, busy=0, done=0, err=0, and clear counters, regardless of current state.
REQ-027 reset release SHALL require a fresh ready strobe before any transmission; an aborted word SHALL NOT resume.

Verification
REQ-028 Reset: reset=0 for 2 cycles, then 1 -> tone=busy=done=err=0; no activity without ready.
REQ-029 DIGITS=1, UNIT_CYCLES=1, number=5, ready pulse -> tone pattern 101010101 over 9 cycles starting the cycle after acceptance; done=1 on cycle 10.
REQ-030 DIGITS=2, UNIT_CYCLES=2, number=8'h10 -> 2 cycles mark, 2 space, four times (6 mark, 2 space minus the final space), 6 cycles gap, five 6-cycle dashes separated by 2-cycle spaces; done exactly 78 cycles after tone first rises.
REQ-031 DIGITS=2, number=8'hA3, ready pulse -> err=1 next cycle, busy=0, tone stays 0; then number=8'h09 accepted -> err=0, transmission starts.
REQ-032 Mid-word: ready and number changed during busy -> ignored; transmitted pattern matches the originally captured word.
REQ-033 Abort: reset=0 during a dash of digit 1 -> tone=0 immediately; after release, no tone until a new ready.
